// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache AXI read/write path arbiters.
//   arb_state_e : burst arbiter state (IDLE -> ADDR -> DATA)
//   SIZE_4B     : AXI arsize encoding for 4-byte beats
//   LINE_BEATS  : beats per cache line; LINE_ARLEN is the matching arlen
//   idx_width() : index width for an N-entry vector, never below 1 bit
package cache_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [2:0]  SIZE_4B    = 3'b010;
  localparam int unsigned LINE_BEATS = 4;
  localparam logic [3:0]  LINE_ARLEN = 4'(LINE_BEATS - 1);

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_axi_rd_arbiter_rr.sv
// Combinational round-robin picker.
//   req         : request vector, one bit per master
//   rr_ptr      : highest-priority index for this pick
//   grant       : one-hot grant (all zero when no request)
//   grant_idx   : binary index of the granted master
//   grant_valid : at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   grant_valid
);

  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cidx;
    cand        = 0;
    cidx        = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Scan from rr_ptr upward; subtract instead of modulo so any N works.
    for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      cidx = IDX_W'(cand);
      if (!grant_valid && req[cidx]) begin
        grant_valid = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// N-master AXI read-burst arbiter: merges per-cache AR/R channels onto one
// downstream AR/R port, one burst outstanding, round-robin grant.
//   m_ar*      : per-master AR channels (packed, master i at [i*W +: W])
//   m_r*       : R data/last broadcast, rvalid/rready per master
//   s_ar*/s_r* : shared downstream AR/R port
//   busy       : a burst is in progress
//   grant_idx  : current / last granted master
//   err_len    : sticky, rlast position disagreed with the latched arlen
module cache_axi_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_araddr,
  input  logic [NUM_MASTERS*LEN_W-1:0]      m_arlen,
  input  logic [NUM_MASTERS*3-1:0]          m_arsize,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [DATA_W-1:0]                 m_rdata,
  output logic                              m_rlast,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [ADDR_W-1:0]                 s_araddr,
  output logic [LEN_W-1:0]                  s_arlen,
  output logic [2:0]                        s_arsize,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  input  logic [DATA_W-1:0]                 s_rdata,
  input  logic                              s_rlast,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  output logic                              busy,
  output logic [idx_width(NUM_MASTERS)-1:0] grant_idx,
  output logic                              err_len
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

  arb_state_e        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [LEN_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [LEN_W-1:0]  lat_len;
  logic [2:0]        lat_size;

  logic [NUM_MASTERS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_valid;

  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [2:0]        sel_size;

  rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req         (m_arvalid),
    .rr_ptr      (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // One-hot AND-OR select of the winning master's AR fields.
  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (arb_grant[i]) begin
        sel_addr = sel_addr | m_araddr[i*ADDR_W +: ADDR_W];
        sel_len  = sel_len  | m_arlen[i*LEN_W +: LEN_W];
        sel_size = sel_size | m_arsize[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      beat_cnt  <= '0;
      lat_addr  <= '0;
      lat_len   <= '0;
      lat_size  <= '0;
      err_len   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_idx;
            lat_addr  <= sel_addr;
            lat_len   <= sel_len;
            lat_size  <= sel_size;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (s_rvalid && s_rready) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (s_rlast) begin
              if (beat_cnt != lat_len) err_len <= 1'b1;
              rr_ptr <= (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
              state  <= IDLE;
            end else if (beat_cnt == lat_len) begin
              // Expected last beat without rlast: flag it, keep forwarding.
              err_len <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_araddr  = lat_addr;
  assign s_arlen   = lat_len;
  assign s_arsize  = lat_size;
  assign s_arvalid = (state == ADDR);
  assign busy      = (state != IDLE);
  assign m_rdata   = s_rdata;
  assign m_rlast   = s_rlast;

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    if (state == ADDR) m_arready[grant_idx] = s_arready;
    if (state == DATA) begin
      m_rvalid[grant_idx] = s_rvalid;
      s_rready            = m_rready[grant_idx];
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Self-checking bench for cache_axi_rd_arbiter (2 masters). The bench plays
// both the masters and the downstream slave; a request-set / pointer model
// predicts every grant, and sticky length-error state is tracked alongside.
module tb_cache_axi_rd_arbiter;
  import cache_axi_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int IW = 1;

  logic             clk;
  logic             rst;
  logic [NM*AW-1:0] m_araddr;
  logic [NM*LW-1:0] m_arlen;
  logic [NM*3-1:0]  m_arsize;
  logic [NM-1:0]    m_arvalid;
  logic [NM-1:0]    m_arready;
  logic [DW-1:0]    m_rdata;
  logic             m_rlast;
  logic [NM-1:0]    m_rvalid;
  logic [NM-1:0]    m_rready;
  logic [AW-1:0]    s_araddr;
  logic [LW-1:0]    s_arlen;
  logic [2:0]       s_arsize;
  logic             s_arvalid;
  logic             s_arready;
  logic [DW-1:0]    s_rdata;
  logic             s_rlast;
  logic             s_rvalid;
  logic             s_rready;
  logic             busy;
  logic [IW-1:0]    grant_idx;
  logic             err_len;

  cache_axi_rd_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .LEN_W       (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .busy      (busy),
    .grant_idx (grant_idx),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          pending [NM];
  logic [31:0] addr    [NM];
  logic [3:0]  len     [NM];
  logic [2:0]  size    [NM];
  int          exp_ptr;
  bit          exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NM; k++) begin
      int i;
      i = (exp_ptr + k) % NM;
      if (pending[i]) return i;
    end
    return 0;
  endfunction

  task automatic drive_masters();
    for (int i = 0; i < NM; i++) begin
      m_araddr[i*AW +: AW] = addr[i];
      m_arlen[i*LW +: LW]  = len[i];
      m_arsize[i*3 +: 3]   = size[i];
      m_arvalid[i]         = pending[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " s_arvalid"}, s_arvalid, 0);
    chk({tag, " s_rready"},  s_rready,  0);
    chk({tag, " m_arready"}, m_arready, 0);
    chk({tag, " m_rvalid"},  m_rvalid,  0);
    chk({tag, " busy"},      busy,      0);
    chk({tag, " grant_idx"}, grant_idx, 0);
    chk({tag, " err_len"},   err_len,   0);
    chk({tag, " s_araddr"},  s_araddr,  0);
    chk({tag, " s_arlen"},   s_arlen,   0);
    chk({tag, " s_arsize"},  s_arsize,  0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases on a negedge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    s_rvalid  = 1'b0;
    s_arready = 1'b0;
    s_rlast   = 1'b0;
    #1 check_reset_outputs(tag);
    exp_ptr = 0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One complete burst as seen from the slave side. Entered on a negedge with
  // the DUT idle and the requests already presented.
  //   rlast_at : beat index carrying rlast (-1 = correct length)
  //   rmode    : 0 always ready, 1 ready pattern 1,0,0,1, 2 random
  //   abort_at : return right after this beat's handshake (-1 = never)
  task automatic serve(input int rlast_at, input bit keep_valid, input int rmode,
                       input logic [DW-1:0] dbase, input int abort_at,
                       output logic [IW-1:0] gd);
    int   g, waited, nbeats, b, cyc;
    logic rr;
    g = pick();
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (s_arvalid !== 1'b1 && waited < 20);
    chk("ar_latency", waited, 1);
    gd = grant_idx;
    chk("grant_idx", grant_idx, g);
    chk("s_araddr",  s_araddr,  addr[g]);
    chk("s_arlen",   s_arlen,   len[g]);
    chk("s_arsize",  s_arsize,  size[g]);
    chk("busy_addr", busy, 1);
    chk("m_arready_idle", m_arready, 0);
    s_arready = 1'b1;
    #1 chk("m_arready", m_arready, 64'(1) << g);
    @(posedge clk);
    #1 s_arready = 1'b0;
    if (!keep_valid) begin
      pending[g] = 0;
      drive_masters();
    end
    nbeats = (rlast_at < 0) ? int'(len[g]) + 1 : rlast_at + 1;
    if (nbeats != int'(len[g]) + 1) exp_err = 1;
    b   = 0;
    cyc = 0;
    while (b < nbeats && cyc < 300) begin
      @(negedge clk);
      s_rvalid = (rmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_rdata  = dbase + DW'(b);
      s_rlast  = (b == nbeats - 1);
      case (rmode)
        1:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       rr = ($urandom_range(0, 2) != 0);
        default: rr = 1'b1;
      endcase
      m_rready    = NM'($urandom);
      m_rready[g] = rr;
      #1;
      chk("m_rvalid", m_rvalid, s_rvalid ? (64'(1) << g) : 64'(0));
      chk("s_rready", s_rready, rr);
      chk("m_rdata",  m_rdata,  dbase + DW'(b));
      chk("m_rlast",  m_rlast,  (b == nbeats - 1));
      chk("busy_data", busy, 1);
      @(posedge clk);
      if (s_rvalid && rr) b++;
      cyc++;
      if (abort_at >= 0 && b > abort_at) return;
    end
    chk("beat_budget", b, nbeats);
    @(negedge clk);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = '0;
    chk("busy_end",    busy,      0);
    chk("arvalid_gap", s_arvalid, 0);
    chk("err_len",     err_len,   exp_err);
    exp_ptr = (g + 1) % NM;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] gd;
    logic [IW-1:0] fair_seq [6];
    int            rl;
    fair_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arvalid = '0; m_rready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    exp_ptr = 0;
    exp_err = 0;
    for (int i = 0; i < NM; i++) begin
      pending[i] = 0; addr[i] = '0; len[i] = '0; size[i] = '0;
    end
    #3 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Single request from master 0
    addr[0] = 32'h1FC0_0000; len[0] = 4'd3; size[0] = SIZE_4B; pending[0] = 1;
    drive_masters();
    serve(-1, 0, 0, 32'h10, -1, gd);
    chk("single_grant", gd, 0);

    // Simultaneous requests straight after reset
    do_reset("rst_a");
    addr[0] = 32'h0000_1000; len[0] = 4'd1; size[0] = SIZE_4B; pending[0] = 1;
    addr[1] = 32'h0000_2000; len[1] = 4'd2; size[1] = SIZE_4B; pending[1] = 1;
    drive_masters();
    serve(-1, 0, 0, 32'h20, -1, gd);
    chk("simul_first", gd, 0);
    serve(-1, 0, 0, 32'h30, -1, gd);
    chk("simul_second", gd, 1);

    // Fairness with both masters requesting continuously
    pending[0] = 1; pending[1] = 1;
    drive_masters();
    for (int k = 0; k < 6; k++) begin
      serve(-1, 1, 0, DW'(32'h100 * k), -1, gd);
      chk("fair_seq", gd, fair_seq[k]);
    end
    pending[0] = 0; pending[1] = 0;
    drive_masters();

    // Backpressure from master 1
    addr[1] = 32'h0000_3000; len[1] = 4'd3; size[1] = SIZE_4B; pending[1] = 1;
    drive_masters();
    serve(-1, 0, 1, 32'hA0, -1, gd);
    chk("bp_grant", gd, 1);

    // Early rlast, then a normal burst; err_len stays set until reset
    addr[0] = 32'h0000_4000; len[0] = 4'd3; pending[0] = 1;
    drive_masters();
    serve(1, 0, 0, 32'hB0, -1, gd);
    addr[1] = 32'h0000_5000; len[1] = 4'd2; pending[1] = 1;
    drive_masters();
    serve(-1, 0, 0, 32'hC0, -1, gd);
    do_reset("rst_err");

    // Reset in the middle of master 1's burst; pointer must restart at 0
    addr[0] = 32'h0000_6000; len[0] = 4'd0; pending[0] = 1;
    drive_masters();
    serve(-1, 0, 0, 32'hD0, -1, gd);
    addr[1] = 32'h0000_7000; len[1] = 4'd3; pending[1] = 1;
    drive_masters();
    serve(-1, 0, 0, 32'hE0, 0, gd);
    do_reset("rst_mid");
    pending[0] = 1; pending[1] = 1;
    drive_masters();
    serve(-1, 0, 0, 32'hF0, -1, gd);
    chk("post_rst_grant", gd, 0);
    serve(-1, 0, 0, 32'hF8, -1, gd);

    // Randomised traffic against the model
    for (int it = 0; it < 40; it++) begin
      bit any;
      any = 0;
      for (int i = 0; i < NM; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1;
          addr[i] = $urandom;
          len[i]  = 4'($urandom_range(0, 7));
          size[i] = 3'($urandom_range(0, 3));
        end
        any |= pending[i];
      end
      if (!any) begin
        int j;
        j = $urandom_range(0, NM - 1);
        pending[j] = 1; addr[j] = $urandom; len[j] = 4'($urandom_range(0, 7)); size[j] = SIZE_4B;
      end
      drive_masters();
      rl = -1;
      if ($urandom_range(0, 4) == 0) begin
        int lg;
        lg = int'(len[pick()]);
        do rl = $urandom_range(0, lg + 2); while (rl == lg);
      end
      serve(rl, ($urandom_range(0, 3) == 0), 2, $urandom, -1, gd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
